// File: rtl/hazard_forward_unit_pkg.sv
// Shared types for the hazard/forwarding controller: operand-mux select
// encoding, shadow-slot metadata and the hardwired-zero register index.
package hazard_pkg;

    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        FWD_NONE  = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_t;

    // Destination-side metadata carried by the EX and MEM shadow slots.
    typedef struct packed {
        logic                  v;
        logic                  we;
        logic                  load;
        logic [REG_ADDR_W-1:0] rd;
    } stage_meta_t;

    // Source-side metadata; only the EX slot needs it for forwarding.
    typedef struct packed {
        logic                  use1;
        logic                  use2;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
    } src_meta_t;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

endpackage

// File: rtl/hazard_forward_unit_if.sv
// ID-stage metadata in, forward selects and stall/bubble requests out.
// master: pipeline control side; slave: hazard_forward_unit.
interface hazard_forward_unit_if
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = REG_ADDR_W
);

    logic                      id_valid_i;
    logic [REG_ADDR_WIDTH-1:0] id_rs1_i;
    logic [REG_ADDR_WIDTH-1:0] id_rs2_i;
    logic                      id_use_rs1_i;
    logic                      id_use_rs2_i;
    logic [REG_ADDR_WIDTH-1:0] id_rd_i;
    logic                      id_we_i;
    logic                      id_is_load_i;
    logic                      hold_i;
    logic                      flush_i;
    fwd_sel_t                  forward_a_o;
    fwd_sel_t                  forward_b_o;
    logic                      stall_if_id_o;
    logic                      bubble_id_ex_o;

    modport master (
        output id_valid_i, id_rs1_i, id_rs2_i,
        output id_use_rs1_i, id_use_rs2_i,
        output id_rd_i, id_we_i, id_is_load_i,
        output hold_i, flush_i,
        input  forward_a_o, forward_b_o,
        input  stall_if_id_o, bubble_id_ex_o
    );

    modport slave (
        input  id_valid_i, id_rs1_i, id_rs2_i,
        input  id_use_rs1_i, id_use_rs2_i,
        input  id_rd_i, id_we_i, id_is_load_i,
        input  hold_i, flush_i,
        output forward_a_o, forward_b_o,
        output stall_if_id_o, bubble_id_ex_o
    );

endinterface

// File: rtl/hazard_forward_unit_fwd_operand_sel.sv
// Priority forward select for one EX operand.
// Ports: use_rs/rs (EX source), mem (MEM slot), wb_* (WB slot), sel.
module fwd_operand_sel
    import hazard_pkg::*;
(
    input  logic                  use_rs,
    input  logic [REG_ADDR_W-1:0] rs,
    input  stage_meta_t           mem,
    input  logic                  wb_v,
    input  logic                  wb_we,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    output fwd_sel_t              sel
);

    logic mem_hit;
    logic wb_hit;

    // A load in MEM has no data on the EX/MEM bus yet, so it is never
    // a forwarding source from that stage.
    assign mem_hit = mem.v & mem.we & ~mem.load
                   & (mem.rd != REG_ZERO) & (mem.rd == rs);

    assign wb_hit = wb_v & wb_we
                  & (wb_rd != REG_ZERO) & (wb_rd == rs);

    // Youngest producer wins.
    always_comb begin
        sel = FWD_NONE;
        if (use_rs & mem_hit) begin
            sel = FWD_EXMEM;
        end else if (use_rs & wb_hit) begin
            sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard and forwarding controller: shadows EX/MEM/WB destination metadata,
// drives operand forward selects and load-use stall/bubble requests.
// Ports: clk_i, rst_i (sync, active-high), bus (hazard_forward_unit_if.slave).
module hazard_forward_unit
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = REG_ADDR_W,
    parameter int DATA_WIDTH     = 32
)
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    hazard_forward_unit_if.slave bus
);

    // Slot metadata is sized by the package; a different width here
    // would silently truncate register indices.
    if (REG_ADDR_WIDTH != REG_ADDR_W || DATA_WIDTH < 1) begin : g_bad_param
        $error("hazard_forward_unit: unsupported parameter values");
    end

    stage_meta_t           ex;
    src_meta_t             ex_src;
    stage_meta_t           mem;
    logic                  wb_v;
    logic                  wb_we;
    logic [REG_ADDR_W-1:0] wb_rd;

    stage_meta_t id_meta;
    src_meta_t   id_src;

    logic hit1;
    logic hit2;
    logic lu;
    logic bubble;

    fwd_sel_t fwd_a;
    fwd_sel_t fwd_b;

    always_comb begin
        id_meta      = '0;
        id_meta.v    = bus.id_valid_i;
        id_meta.we   = bus.id_we_i;
        id_meta.load = bus.id_is_load_i;
        id_meta.rd   = bus.id_rd_i;
    end

    always_comb begin
        id_src      = '0;
        id_src.use1 = bus.id_use_rs1_i;
        id_src.use2 = bus.id_use_rs2_i;
        id_src.rs1  = bus.id_rs1_i;
        id_src.rs2  = bus.id_rs2_i;
    end

    assign hit1 = bus.id_use_rs1_i & (bus.id_rs1_i == ex.rd);
    assign hit2 = bus.id_use_rs2_i & (bus.id_rs2_i == ex.rd);

    assign lu = ex.v & ex.load & ex.we & (ex.rd != REG_ZERO)
              & bus.id_valid_i & (hit1 | hit2);

    // A freeze defers everything; a flush overrides the stall because the
    // consumer in ID is being discarded anyway.
    assign bubble = (lu | bus.flush_i) & ~bus.hold_i;

    assign bus.stall_if_id_o  = lu & ~bus.flush_i & ~bus.hold_i;
    assign bus.bubble_id_ex_o = bubble;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex     <= '0;
            ex_src <= '0;
            mem    <= '0;
            wb_v   <= 1'b0;
            wb_we  <= 1'b0;
            wb_rd  <= '0;
        end else if (!bus.hold_i) begin
            wb_v  <= mem.v;
            wb_we <= mem.we;
            wb_rd <= mem.rd;
            mem   <= ex;
            if (bubble) begin
                // Clearing the sources too keeps a bubble from forwarding.
                ex     <= '0;
                ex_src <= '0;
            end else begin
                ex     <= id_meta;
                ex_src <= id_src;
            end
        end
    end

    fwd_operand_sel u_fwd_a (
        .use_rs (ex_src.use1),
        .rs     (ex_src.rs1),
        .mem    (mem),
        .wb_v   (wb_v),
        .wb_we  (wb_we),
        .wb_rd  (wb_rd),
        .sel    (fwd_a)
    );

    fwd_operand_sel u_fwd_b (
        .use_rs (ex_src.use2),
        .rs     (ex_src.rs2),
        .mem    (mem),
        .wb_v   (wb_v),
        .wb_we  (wb_we),
        .wb_rd  (wb_rd),
        .sel    (fwd_b)
    );

    assign bus.forward_a_o = fwd_a;
    assign bus.forward_b_o = fwd_b;

endmodule

// File: doc/hazard_forward_unit.md
# hazard_forward_unit

Pipeline hazard and forwarding controller for the 5-stage core. It tracks destination-register metadata for the instructions in EX, MEM and WB in a shadow pipeline. From that it drives the 2-bit `forward` selects that the EX-stage operand muxes consume. It also detects load-use hazards and requests a one-cycle IF/ID hold with an ID/EX bubble.

## Interface
Parameters:
- `REG_ADDR_WIDTH`, default 5: register index width.
- `DATA_WIDTH`, default 32: datapath width. Carried for uniformity; no data passes through this block.

Ports:
- `clk_i` input, 1 bit: core clock. This is the only clock.
- `rst_i` input, 1 bit: reset. Synchronous and active-high.
- `id_valid_i` input, 1 bit: the ID-stage instruction is real (not a bubble).
- `id_rs1_i`, `id_rs2_i` input, REG_ADDR_WIDTH bits: source registers of the ID instruction.
- `id_use_rs1_i`, `id_use_rs2_i` input, 1 bit each: the ID instruction actually reads rs1 / rs2.
- `id_rd_i` input, REG_ADDR_WIDTH bits: destination register of the ID instruction.
- `id_we_i` input, 1 bit: the ID instruction writes rd.
- `id_is_load_i` input, 1 bit: the ID instruction is a load.
- `hold_i` input, 1 bit: whole-pipeline freeze (memory wait).
- `flush_i` input, 1 bit: kill the ID instruction (branch redirect).
- `forward_a_o`, `forward_b_o` output, 2 bits each: operand selects for the EX operand muxes. 00 = register/PC path, 01 = EX/MEM data, 10 = MEM/WB data.
- `stall_if_id_o` output, 1 bit: hold the PC and the IF/ID register this cycle.
- `bubble_id_ex_o` output, 1 bit: load a bubble into ID/EX this cycle.

## Operation
Shadow registers:
- EX slot: `ex_v`, `ex_rd`, `ex_we`, `ex_load`, `ex_rs1`, `ex_rs2`, `ex_use1`, `ex_use2`.
- MEM slot: `mem_v`, `mem_rd`, `mem_we`, `mem_load`.
- WB slot: `wb_v`, `wb_rd`, `wb_we`.

Load-use hazard:
- `lu` = `ex_v & ex_load & ex_we & ex_rd!=0 & id_valid_i & ((id_use_rs1_i & id_rs1_i==ex_rd) | (id_use_rs2_i & id_rs2_i==ex_rd))`.
- `stall_if_id_o` = `lu & !flush_i & !hold_i`.
- `bubble_id_ex_o` = `(lu | flush_i) & !hold_i`.

Advance (only when `hold_i`=0):
- WB slot takes the MEM slot.
- MEM slot takes the EX slot.
- EX slot takes the ID fields, or a bubble (`ex_v`=0, `ex_we`=0) when `bubble_id_ex_o`=1.

When `hold_i`=1, all slots are frozen and `flush_i` is ignored. The flush source must keep `flush_i` asserted until `hold_i` drops.

Forward select, per operand (shown for A; B uses rs2 and use2):
- 01 if `ex_use1 & mem_v & mem_we & !mem_load & mem_rd!=0 & mem_rd==ex_rs1`.
- else 10 if `ex_use1 & wb_v & wb_we & wb_rd!=0 & wb_rd==ex_rs1`.
- else 00.
- EX/MEM has priority over MEM/WB, so the youngest producer wins.

Invariants:
- x0 is never forwarded and never causes a stall.
- A load in MEM matching an EX source cannot occur, because a load-use bubble always precedes it. It must never produce select 01; the bench asserts this.
- WB-to-ID same-cycle hazards are outside this block. The register file is write-first.

## Timing
Reset (`rst_i` high at a clock edge):
- All `*_v` and `*_we` clear.
- `forward_a_o`/`forward_b_o` = 00.
- `stall_if_id_o` = 0 and `bubble_id_ex_o` = 0 in the cycle after reset, provided `flush_i`=0.
- Reset overrides `hold_i` and `flush_i`. Reset mid-stall drops the pending stall.

Forward selects:
- Depend only on shadow registers, with no input-to-output path.
- Valid from the start of the cycle the consumer is in EX.

Stall and bubble:
- `stall_if_id_o` and `bubble_id_ex_o` are combinational from the ID inputs plus state.
- A load-use stall lasts exactly 1 cycle (absent `hold_i`). Next cycle the load is in MEM, the bubble is in EX, and `lu`=0.
- After the stall, the consumer enters EX with the load in WB, so the select is 10.
- `flush_i` together with `lu`: the flush wins, the stall is 0, and the bubble is 1.
- `hold_i` during `lu`: the stall is deferred with no state change. It is evaluated again when `hold_i` falls.

## Structure
- Package `hazard_pkg` holds:
  - typedef `fwd_sel_t`: FWD_NONE=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10. This same type is shared with the operand-mux select ports.
  - typedef `stage_meta_t`: the struct of the slot fields.
  - constant `REG_ZERO`.
- Sub-module `fwd_operand_sel`: combinational priority compare for one operand, instantiated twice (A, B).

## Test plan
- Back-to-back ALU dependency: `add x5` then `sub x6,x5,x1`.
  - Required: the consumer in EX sees `forward_a_o`=01; no stall.
- Distance-2 dependency: producer, one unrelated instruction, consumer reading x5 as rs2.
  - Required: `forward_b_o`=10.
- Priority: two writers of x7 in MEM and WB.
  - Required: select 01.
- Load-use: `lw x8` then `add x9,x8,x8`.
  - Required: `stall_if_id_o` and `bubble_id_ex_o` = 1 for exactly 1 cycle.
  - Required: then `forward_a_o` = `forward_b_o` = 10.
- x0 and unused sources:
  - `lw x0` followed by a reader of x0: no stall, select 00.
  - `lw x8` followed by an immediate op with `id_use_rs2_i`=0 and rs2 field=8: no stall.
- Interactions:
  - `hold_i` held for 3 cycles during a load-use: outputs and slots frozen; the stall fires once after release.
  - `flush_i` with `lu`: bubble=1, stall=0.
  - `rst_i` mid-stall: all outputs 0 next cycle.
